diram_sdr_responder: RTL and testbench
======================================

// Module: diram_sdr_responder
// PURPOSE
//  Single-clock SDR responder for the scheduler-side DiRAM4 interface. It accepts cs/cmd/addr/bank/wrdata
//  from the scheduler and returns dfi__sch__rddata with dfi__sch__rddata_valid, as the DFI+DiRAM pair would.
//  It tracks per-bank open pages, stores write data and returns read data after a fixed latency.
//  It checks the command protocol, so the scheduler can be closed-loop tested without the DDR phy.
// PARAMETERS
//  DIRAM_WIDTH       32   per-port DiRAM data width
//  burst_length_dsdr 2    beats per SDR word
//  PORT_NO           5    number of ports; data bus width W = DIRAM_WIDTH*burst_length_dsdr*PORT_NO (320)
//  MEM_ADDR_BITS     8    storage depth = 2**MEM_ADDR_BITS words of W bits
//  RD_LATENCY        4    cycles from read command to rddata_valid (legal range 1..15)
//  ACT_TO_RW         2    minimum cycles between activate and read/write to the same bank
//  INIT_CYCLES       16   cycles after reset release before init_done asserts
// PORTS
//  clk                     in   1    core clock
//  reset                   in   1    synchronous, active-high
//  dfi__sch__init_done     out  1    responder ready for commands
//  sch__dfi__cs            in   1    command strobe, active-high
//  sch__dfi__cmd1          in   1    command bit 1
//  sch__dfi__cmd0          in   1    command bit 0
//  sch__dfi__addr          in   `DFI_TOP_DIRAM4_ADDRESS_RANGE  activate: 12-bit page; rd/wr: addr[3:0] = block
//  sch__dfi__bank          in   `DFI_TOP_DIRAM4_BANK_RANGE     bank select; NB = 2**width banks
//  sch__dfi__wrdata        in   W    write data, valid in the write command cycle
//  dfi__sch__rddata        out  W    read data
//  dfi__sch__rddata_valid  out  1    read data qualifier, one cycle per read
//  resp__err               out  1    sticky protocol error
//  resp__err_code          out  3    code of the first error; held until reset
// BEHAVIOUR
//  - Reset: init_done=0, rddata=0, rddata_valid=0, err=0, err_code=0, all banks CLOSED, read pipe flushed.
//    Storage contents are not reset.
//  - Init: a counter runs from reset release; init_done=1 from cycle INIT_CYCLES onward, then stays 1.
//  - Command decode applies only when cs=1; cs=0 is a NOP. {cmd1,cmd0}: 00=ACT, 01=RD, 10=WR, 11=PRE.
//  - Bank FSM, one per bank:
//    CLOSED --ACT--> OPEN (page<=addr[15:4], act_cnt<=ACT_TO_RW)
//    OPEN   --PRE--> CLOSED
//    act_cnt decrements to 0 and saturates there.
//  - Storage index = {bank, page, block} truncated to the low MEM_ADDR_BITS bits.
//  - WR: mem[idx] <= wrdata at the clock edge of the command cycle.
//  - RD: mem[idx] is read in the command cycle, then passed through a RD_LATENCY-deep shift pipe of
//    {valid,data}. A RD at cycle N gives valid=1 at cycle N+RD_LATENCY. The pipe accepts one read per cycle.
//  - Back-to-back WR then RD to the same idx: the RD returns the new data (the write commits first).
//  - A reset asserted mid-read flushes the pipe; no valid is issued for reads in flight.
//  - rddata holds its last value while valid=0.
//  - Error codes; the first error latches err=1 and err_code:
//    1 = command while init_done=0 (command ignored)
//    2 = RD/WR to a CLOSED bank
//    3 = RD/WR while act_cnt!=0
//    4 = ACT to an OPEN bank (page is still replaced)
//    PRE to a CLOSED bank is a legal NOP.
//  - An errored RD still returns data (using the last page) so the scheduler pipeline keeps flowing.
// CONFIGURATION
//  DIRAM_RESP_PROT_CHECK_EN defined:
//    the error checks above are active; code-1 commands are ignored.
//  DIRAM_RESP_PROT_CHECK_EN undefined:
//    resp__err and resp__err_code are tied to 0.
//    All commands execute, including before init_done; init_done still follows INIT_CYCLES.
//    RD/WR to a CLOSED bank uses the last page (0 after reset).
//    act_cnt logic is removed.
// TESTING
//  1. Reset release -> init_done=0 through cycle 15, init_done=1 at cycle 16; all outputs 0 during reset.
//  2. ACT b0 page 0x012; wait 2; WR blk 3 data 0xA5..A5; RD blk 3 at cycle N
//     -> valid=1 with data 0xA5..A5 at N+4 only.
//  3. Four consecutive RDs to blocks 0..3 -> four consecutive valid cycles, data in order, no gaps.
//  4. RD b1 with b1 CLOSED (CHECK_EN) -> err=1, code=2; a later ACT to open b0 -> code stays 2.
//  5. ACT b2, RD b2 on the next cycle (CHECK_EN) -> err=1, code=3;
//     without the macro -> no error, read data returned.
//  6. RD issued, reset pulsed 2 cycles later -> no valid ever appears; all banks CLOSED after reset.

Source files
------------

// File: rtl/diram_sdr_responder.sv
// SDR-side DiRAM4 responder: per-bank page tracking, word storage and fixed-latency read return.
// Protocol checking on resp__err/resp__err_code is built only when DIRAM_RESP_PROT_CHECK_EN is defined.
`ifndef DFI_TOP_DIRAM4_ADDRESS_RANGE
`define DFI_TOP_DIRAM4_ADDRESS_RANGE 15:0
`endif
`ifndef DFI_TOP_DIRAM4_BANK_RANGE
`define DFI_TOP_DIRAM4_BANK_RANGE 1:0
`endif

module diram_sdr_responder #(
    parameter int unsigned DIRAM_WIDTH       = 32,
    parameter int unsigned burst_length_dsdr = 2,
    parameter int unsigned PORT_NO           = 5,
    parameter int unsigned MEM_ADDR_BITS     = 8,
    parameter int unsigned RD_LATENCY        = 4,
    parameter int unsigned ACT_TO_RW         = 2,
    parameter int unsigned INIT_CYCLES       = 16,
    localparam int unsigned W = DIRAM_WIDTH * burst_length_dsdr * PORT_NO
) (
    input  logic                                  clk,
    input  logic                                  reset,
    output logic                                  dfi__sch__init_done,
    input  logic                                  sch__dfi__cs,
    input  logic                                  sch__dfi__cmd1,
    input  logic                                  sch__dfi__cmd0,
    input  logic [`DFI_TOP_DIRAM4_ADDRESS_RANGE]  sch__dfi__addr,
    input  logic [`DFI_TOP_DIRAM4_BANK_RANGE]     sch__dfi__bank,
    input  logic [W-1:0]                          sch__dfi__wrdata,
    output logic [W-1:0]                          dfi__sch__rddata,
    output logic                                  dfi__sch__rddata_valid,
    output logic                                  resp__err,
    output logic [2:0]                            resp__err_code
);
    localparam int unsigned BW    = $bits(sch__dfi__bank);
    localparam int unsigned NB    = 2 ** BW;
    localparam int unsigned IW    = BW + 16;
    localparam int unsigned DEPTH = 2 ** MEM_ADDR_BITS;
    localparam int unsigned ICW   = $clog2(INIT_CYCLES + 2);

    typedef enum logic [1:0] {CMD_ACT = 2'b00, CMD_RD = 2'b01, CMD_WR = 2'b10, CMD_PRE = 2'b11} cmd_e;

    cmd_e                 cmd;
    logic                 exec;
    logic                 is_act, is_rd, is_wr, is_pre;
    logic [ICW-1:0]       init_cnt;
    logic [11:0]          page_q [NB];
    logic [IW-1:0]        full_idx;
    logic [MEM_ADDR_BITS-1:0] idx;
    logic                 unused_idx_bits;
    logic [W-1:0]         mem [DEPTH];
    logic [RD_LATENCY-1:0] pipe_v, in_v;
    logic [W-1:0]         pipe_d [RD_LATENCY];
    logic [W-1:0]         in_d   [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (reset)
            init_cnt <= '0;
        else if (init_cnt != ICW'(INIT_CYCLES))
            init_cnt <= init_cnt + ICW'(1);
    end
    assign dfi__sch__init_done = (init_cnt == ICW'(INIT_CYCLES));

    assign cmd    = cmd_e'({sch__dfi__cmd1, sch__dfi__cmd0});
    assign is_act = exec && (cmd == CMD_ACT);
    assign is_rd  = exec && (cmd == CMD_RD);
    assign is_wr  = exec && (cmd == CMD_WR);
    assign is_pre = exec && (cmd == CMD_PRE);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < NB; b++)
                page_q[b] <= '0;
        end else if (is_act) begin
            page_q[sch__dfi__bank] <= sch__dfi__addr[15:4];
        end
    end

    // Only the low MEM_ADDR_BITS of {bank,page,block} address storage.
    assign full_idx        = {sch__dfi__bank, page_q[sch__dfi__bank], sch__dfi__addr[3:0]};
    assign idx             = full_idx[MEM_ADDR_BITS-1:0];
    assign unused_idx_bits = ^full_idx;

    always_ff @(posedge clk) begin
        if (is_wr)
            mem[idx] <= sch__dfi__wrdata;
    end

    always_comb begin
        in_v = '0;
        for (int unsigned k = 0; k < RD_LATENCY; k++)
            in_d[k] = '0;
        in_v[0] = is_rd;
        in_d[0] = mem[idx];
        for (int unsigned k = 1; k < RD_LATENCY; k++) begin
            in_v[k] = pipe_v[k-1];
            in_d[k] = pipe_d[k-1];
        end
    end

    // The last stage is the output register: it loads only on valid so rddata holds between reads.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < RD_LATENCY; k++) begin
            if (k != RD_LATENCY - 1 || in_v[k])
                pipe_d[k] <= in_d[k];
        end
        if (reset) begin
            pipe_v                 <= '0;
            pipe_d[RD_LATENCY-1]   <= '0;
        end else begin
            pipe_v <= in_v;
        end
    end

    assign dfi__sch__rddata       = pipe_d[RD_LATENCY-1];
    assign dfi__sch__rddata_valid = pipe_v[RD_LATENCY-1];

`ifdef DIRAM_RESP_PROT_CHECK_EN
    localparam int unsigned CW = $clog2(ACT_TO_RW + 2);

    typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} bank_e;

    bank_e          bank_q [NB];
    bank_e          bank_d [NB];
    logic [CW-1:0]  act_cnt_q [NB];
    logic [CW-1:0]  act_cnt_d [NB];
    logic [2:0]     code_now;
    logic           err_q;
    logic [2:0]     code_q;

    // Commands before init_done are flagged and dropped; other errors still execute.
    always_comb begin
        exec     = sch__dfi__cs && !reset;
        code_now = '0;
        if (exec) begin
            if (!dfi__sch__init_done) begin
                code_now = 3'd1;
                exec     = 1'b0;
            end else begin
                case (cmd)
                    CMD_RD, CMD_WR: begin
                        if (bank_q[sch__dfi__bank] == CLOSED)
                            code_now = 3'd2;
                        else if (act_cnt_q[sch__dfi__bank] != '0)
                            code_now = 3'd3;
                    end
                    CMD_ACT: begin
                        if (bank_q[sch__dfi__bank] == OPEN)
                            code_now = 3'd4;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < NB; b++) begin
            bank_d[b]    = bank_q[b];
            act_cnt_d[b] = (act_cnt_q[b] != '0) ? act_cnt_q[b] - CW'(1) : '0;
        end
        if (is_act) begin
            bank_d[sch__dfi__bank]    = OPEN;
            act_cnt_d[sch__dfi__bank] = CW'(ACT_TO_RW);
        end
        if (is_pre)
            bank_d[sch__dfi__bank] = CLOSED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < NB; b++) begin
                bank_q[b]    <= CLOSED;
                act_cnt_q[b] <= '0;
            end
            err_q  <= 1'b0;
            code_q <= '0;
        end else begin
            bank_q    <= bank_d;
            act_cnt_q <= act_cnt_d;
            if (!err_q && code_now != '0) begin
                err_q  <= 1'b1;
                code_q <= code_now;
            end
        end
    end

    assign resp__err      = err_q;
    assign resp__err_code = code_q;
`else
    assign exec           = sch__dfi__cs && !reset;
    assign resp__err      = 1'b0;
    assign resp__err_code = '0;
`endif

endmodule

// File: tb/tb_diram_sdr_responder.sv
// Randomized bench for diram_sdr_responder against a cycle-indexed behavioural model (queue of timed reads,
// associative storage, per-bank open/page/activate-time); adapts its error expectations to DIRAM_RESP_PROT_CHECK_EN.
module tb_diram_sdr_responder;
    localparam int W    = 320;
    localparam int LAT  = 4;
    localparam int ACTW = 2;
    localparam int INIT = 16;
    localparam int MAB  = 8;
    localparam logic [1:0] OP_ACT = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10, OP_PRE = 2'b11;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cs = 1'b0, cmd1 = 1'b0, cmd0 = 1'b0;
    logic [15:0]  addr = '0;
    logic [1:0]   bank = '0;
    logic [W-1:0] wrdata = '0;
    logic         init_done, valid, err;
    logic [W-1:0] rddata;
    logic [2:0]   err_code;

    always #5 clk = ~clk;

    diram_sdr_responder #(
        .DIRAM_WIDTH(32), .burst_length_dsdr(2), .PORT_NO(5), .MEM_ADDR_BITS(MAB),
        .RD_LATENCY(LAT), .ACT_TO_RW(ACTW), .INIT_CYCLES(INIT)
    ) dut (
        .clk(clk), .reset(reset), .dfi__sch__init_done(init_done),
        .sch__dfi__cs(cs), .sch__dfi__cmd1(cmd1), .sch__dfi__cmd0(cmd0),
        .sch__dfi__addr(addr), .sch__dfi__bank(bank), .sch__dfi__wrdata(wrdata),
        .dfi__sch__rddata(rddata), .dfi__sch__rddata_valid(valid),
        .resp__err(err), .resp__err_code(err_code)
    );

    typedef struct {int due; logic [W-1:0] data;} rd_t;

    int            n_chk = 0, n_err = 0;
    int            t = 0;
    bit            run = 0;
    bit            chk_en;
    rd_t           rdq[$];
    logic [W-1:0]  mem_m [int];
    bit            open_m [4];
    logic [11:0]   page_m [4];
    int            act_t [4];
    logic          m_err;
    logic [2:0]    m_code;
    logic [W-1:0]  last_data;
    logic          ev;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s t=%0d: got %h want %h", name, t, got, want);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic void model_reset();
        rdq.delete();
        last_data = '0;
        m_err = 1'b0;
        m_code = '0;
        for (int b = 0; b < 4; b++) begin
            open_m[b] = 0;
            page_m[b] = '0;
            act_t[b] = -100;
        end
        t = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else t++;
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input int b, input logic [15:0] a, input logic [W-1:0] d);
        int code, idx, t0;
        bit exec;
        cs = 1'b1; {cmd1, cmd0} = op; bank = b[1:0]; addr = a; wrdata = d;
        code = 0; exec = 1; t0 = t;
        if (chk_en) begin
            if (t < INIT) begin code = 1; exec = 0; end
            else if (op == OP_RD || op == OP_WR) begin
                if (!open_m[b]) code = 2;
                else if (t < act_t[b] + ACTW + 1) code = 3;
            end else if (op == OP_ACT && open_m[b]) code = 4;
        end
        idx = ((b << 16) | (int'(page_m[b]) << 4) | int'(a[3:0])) % (1 << MAB);
        @(posedge clk);
        if (exec) begin
            case (op)
                OP_ACT: begin open_m[b] = 1; page_m[b] = a[15:4]; act_t[b] = t0; end
                OP_RD:  rdq.push_back('{t0 + LAT, mem_m[idx]});
                OP_WR:  mem_m[idx] = d;
                default: open_m[b] = 0;
            endcase
        end
        if (code != 0 && !m_err) begin m_err = 1'b1; m_code = code[2:0]; end
        t++;
        #1;
        cs = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_init();
        while (t < INIT) tick();
    endtask

    task automatic chk_err(input string name, input logic e, input logic [2:0] c);
        chk({name, "_err"}, err, chk_en ? e : 1'b0);
        chk({name, "_code"}, err_code, chk_en ? c : 3'd0);
    endtask

    always @(negedge clk) begin
        if (run) begin
            ev = 1'b0;
            if (rdq.size() > 0 && rdq[0].due == t) begin
                ev = 1'b1;
                last_data = rdq[0].data;
                void'(rdq.pop_front());
            end
            chk("init_done", init_done, t >= INIT);
            chk("rddata_valid", valid, ev);
            chk("rddata", rddata, last_data);
            chk("err", err, m_err);
            chk("err_code", err_code, m_code);
        end
    end

    initial begin
        logic [W-1:0] pat [8];
        logic [W-1:0] a5;
`ifdef DIRAM_RESP_PROT_CHECK_EN
        chk_en = 1;
`else
        chk_en = 0;
`endif
        a5 = {40{8'hA5}};
        for (int i = 0; i < 8; i++) pat[i] = {10{32'h1000_0000 + i}};
        model_reset();
        tick();
        run = 1;
        do_reset(2);

        // Init timing and early-command handling.
        repeat (3) tick();
        issue(OP_WR, 0, 16'h0000, rnd_w());
        while (t < INIT - 1) tick();
        chk("init_c15", init_done, 1'b0);
        tick();
        chk("init_c16", init_done, 1'b1);
        chk_err("early_cmd", 1'b1, 3'd1);
        do_reset(2);
        wait_init();

        // Fill storage: idx = {page[3:0], block} for the 8-bit depth.
        for (int p = 0; p < 16; p++) begin
            issue(OP_ACT, 0, {p[11:0], 4'h0}, '0);
            tick(); tick();
            for (int blk = 0; blk < 16; blk++) issue(OP_WR, 0, {p[11:0], blk[3:0]}, rnd_w());
            issue(OP_PRE, 0, '0, '0);
        end

        // Write then read, fixed latency.
        issue(OP_ACT, 0, {12'h012, 4'h0}, '0);
        tick(); tick();
        issue(OP_WR, 0, {12'h012, 4'h3}, a5);
        issue(OP_RD, 0, {12'h012, 4'h3}, '0);
        for (int k = 1; k <= 5; k++) begin
            chk("lat_valid", valid, k == LAT);
            if (k == LAT) chk("lat_data", rddata, a5);
            tick();
        end
        chk_err("legal_seq", 1'b0, 3'd0);

        // Back-to-back reads return in order without gaps, then hold.
        for (int i = 0; i < 4; i++) issue(OP_WR, 0, {12'h012, 4'(i + 4)}, pat[i]);
        for (int i = 0; i < 4; i++) issue(OP_RD, 0, {12'h012, 4'(i + 4)}, '0);
        for (int k = 0; k <= 4; k++) begin
            chk("b2b_valid", valid, k < 4);
            chk("b2b_data", rddata, pat[k < 4 ? k : 3]);
            tick();
        end

        // Read too soon after activate.
        issue(OP_ACT, 2, {12'h012, 4'h0}, '0);
        issue(OP_RD, 2, {12'h012, 4'h3}, '0);
        chk_err("act_to_rw", 1'b1, 3'd3);
        for (int k = 1; k <= LAT; k++) begin
            if (k == LAT) begin
                chk("early_rd_valid", valid, 1'b1);
                chk("early_rd_data", rddata, a5);
            end
            tick();
        end

        // Closed-bank access, then a later error must not overwrite the code.
        do_reset(2);
        wait_init();
        issue(OP_RD, 1, 16'h0005, '0);
        chk_err("closed_rd", 1'b1, 3'd2);
        issue(OP_ACT, 0, {12'h001, 4'h0}, '0);
        issue(OP_ACT, 0, {12'h002, 4'h0}, '0);
        tick();
        chk_err("sticky", 1'b1, 3'd2);
        repeat (LAT) tick();

        // Reset during an in-flight read.
        issue(OP_RD, 0, 16'h0021, '0);
        tick();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("flush_valid", valid, 1'b0);
            tick();
        end
        wait_init();
        issue(OP_WR, 0, 16'h0000, pat[7]);
        chk_err("closed_after_rst", 1'b1, 3'd2);
        tick();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 7)
                issue(2'($urandom_range(0, 3)), $urandom_range(0, 3),
                      16'($urandom_range(0, 65535)), rnd_w());
            else
                tick();
        end
        repeat (LAT + 2) tick();
        run = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
